// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch types and constants
package riscv_pkg;

    localparam int XLEN = 32;

    // Canonical NOP (addi x0, x0, 0) shown to the decoder when nothing is buffered
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - instruction buffer FIFO with flush
module fetch_fifo #(
    parameter int BUF_DEPTH = 2,
    parameter int WIDTH     = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(BUF_DEPTH):0]   count_o
);

    localparam int AW = $clog2(BUF_DEPTH);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Flush wins over push and pop; a pop of an empty buffer is ignored
    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with redirect and prefetch buffer
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int            CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(BUF_DEPTH);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0]   buf_count;
    logic [63:0]     buf_head;
    logic [CW:0]     occupancy;
    logic            accept, push, pop;

    // Buffered entries plus the in-flight request form the credit already spent
    assign occupancy     = {1'b0, buf_count} + (CW+1)'(state_q == WAIT);
    assign imem_req_addr = fetch_pc_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a redirect turns any stale in-flight request into a drain
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = REQ;
            REQ:   if (accept) state_d = redirect_valid ? DRAIN : WAIT;
            WAIT:  begin
                if (imem_rsp_valid)      state_d = REQ;
                else if (redirect_valid) state_d = DRAIN;
            end
            DRAIN: if (imem_rsp_valid) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and buffer controls; redirect suppresses push and pop
    always_comb begin
        imem_req_valid = (state_q == REQ) && (occupancy < DEPTH_C);
        accept         = (state_q == REQ) && (occupancy < DEPTH_C) && imem_req_ready;
        push           = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;
        instr_valid    = (buf_count != '0);
        pop            = (buf_count != '0) && instr_ready && !redirect_valid;
        instr          = (buf_count != '0) ? buf_head[63:32] : INSTR_NOP;
        instr_pc       = (buf_count != '0) ? buf_head[31:0]  : '0;
    end

    // Fetch PC advances on acceptance; redirect overrides with a word-aligned target
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (redirect_valid) fetch_pc_d = redirect_pc & ~32'h3;
    end

    // Fetch PC and outstanding-request PC registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH),
        .WIDTH     (64)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({imem_rsp_data, req_pc_q}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (buf_head),
        .count_o     (buf_count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ready_pct = 100;
    int          dec_pct   = 100;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          acc_cnt   = 0;
    logic [31:0] acc_last  = '0;
    bit          redir_prev = 1'b0;
    pend_t       pend_q[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Program-order stream: the decoder must see consecutive words from the last target
    function automatic void refill();
        while (exp_q.size() < 4) exp_q.push_back(exp_q[exp_q.size()-1] + 32'd4);
    endfunction

    function automatic void restart(input logic [31:0] pc);
        exp_q.delete();
        exp_q.push_back(pc);
        refill();
    endfunction

    // Instruction memory: one response per accepted request after a random latency
    initial begin : mem_proc
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) pend_q.delete();
            imem_rsp_valid = 1'b0;
            if (rst_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memfn(pend_q[0].addr);
                void'(pend_q.pop_front());
            end
            imem_req_ready = (int'($urandom_range(99, 0)) < ready_pct);
        end
    end

    // Decoder readiness
    initial begin : dec_proc
        instr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            instr_ready = (int'($urandom_range(99, 0)) < dec_pct);
        end
    end

    // Monitor: evaluates each cycle's handshakes mid-cycle against the scoreboard
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                restart(RESET_PC);
                redir_prev = 1'b0;
                continue;
            end
            if (redir_prev) check("flush_empty", instr_valid, 1'b0);
            if (imem_req_valid && imem_req_ready) begin
                int l;
                l = int'($urandom_range(lat_max, lat_min));
                check("one_outstanding", pend_q.size(), 0);
                check("addr_align", imem_req_addr[1:0], 2'b00);
                pend_q.push_back('{imem_req_addr, cyc + l});
                acc_last = imem_req_addr;
                acc_cnt++;
            end
            if (dut.u_fifo.push_i) check("no_overflow", dut.u_fifo.count_o < BUF_DEPTH, 1'b1);
            if (instr_valid && instr_ready) begin
                check("instr_pc", instr_pc, exp_q[0]);
                check("instr_data", instr, memfn(exp_q[0]));
                void'(exp_q.pop_front());
                refill();
            end
            if (redirect_valid) restart(redirect_pc & ~32'h3);
            redir_prev = redirect_valid;
        end
    end

    task automatic wait_accept();
        int  start;
        bit  got;
        start = acc_cnt;
        got   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: no request accepted within 100 cycles");
        end
    endtask

    task automatic wait_addr(input logic [31:0] target, input string name);
        for (int k = 0; k < 4; k++) begin
            wait_accept();
            if (acc_last == target) break;
        end
        check(name, acc_last, target);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit got;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch with a 1-cycle memory
        wait_accept();
        check("seq_addr0", acc_last, 32'h0);
        check("lat_not_yet", instr_valid, 1'b0);
        @(posedge clk);
        #1;
        check("lat_valid", instr_valid, 1'b1);
        wait_accept();
        check("seq_addr1", acc_last, 32'h4);
        wait_accept();
        check("seq_addr2", acc_last, 32'h8);

        // Decoder stall fills the buffer and stops requests
        dec_pct = 0;
        repeat (10) @(posedge clk);
        #1;
        check("stall_count", dut.u_fifo.count_o, 2);
        check("stall_req_valid", imem_req_valid, 1'b0);
        check("stall_instr_valid", instr_valid, 1'b1);
        dec_pct = 100;
        lat_min = 2;
        lat_max = 2;
        repeat (6) @(posedge clk);

        // Redirect while waiting; stale response lands in DRAIN
        wait_accept();
        pulse_redirect(32'h100);
        wait_accept();
        check("redir_wait_addr", acc_last, 32'h100);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (instr_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("redir_first_pc", instr_pc, 32'h100);

        // Redirect coinciding with the response
        wait_accept();
        @(posedge clk);
        #1;
        pulse_redirect(32'h203);
        wait_accept();
        check("redir_rsp_addr", acc_last, 32'h200);

        // Address wrap at the top of memory
        lat_min = 1;
        lat_max = 1;
        pulse_redirect(32'hFFFF_FFF8);
        wait_addr(32'hFFFF_FFF8, "wrap_start");
        wait_accept();
        check("wrap_fffc", acc_last, 32'hFFFF_FFFC);
        wait_accept();
        check("wrap_zero", acc_last, 32'h0);

        // Reset in the middle of a request with one instruction buffered
        dec_pct = 0;
        lat_min = 3;
        lat_max = 3;
        pulse_redirect(32'h40);
        wait_addr(32'h44, "pre_reset_addr");
        check("pre_reset_buffered", instr_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("reset_instr_valid", instr_valid, 1'b0);
        check("reset_req_valid", imem_req_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        dec_pct = 100;
        lat_min = 1;
        lat_max = 1;
        wait_accept();
        check("post_reset_addr", acc_last, RESET_PC);

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 2000; c++) begin
            if (c % 50 == 0) begin
                ready_pct = int'($urandom_range(100, 30));
                dec_pct   = int'($urandom_range(100, 20));
                lat_max   = int'($urandom_range(4, 1));
            end
            @(posedge clk);
            #1;
            redirect_valid = ($urandom_range(99, 0) < 3);
            if ($urandom_range(3, 0) == 0) redirect_pc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            else                           redirect_pc = $urandom;
        end
        redirect_valid = 1'b0;
        dec_pct        = 100;
        ready_pct      = 100;
        repeat (30) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning: first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, default 2, meaning: instruction buffer entries (power of two, >=2).
REQ-003 Port clk  input  1  meaning: single clock, all state rising-edge.
REQ-004 Port rst_n  input  1  meaning: reset, asynchronous, active-low.
REQ-005 Port imem_req_valid  output  1  meaning: fetch request to instruction memory.
REQ-006 Port imem_req_ready  input  1  meaning: memory accepts request this cycle.
REQ-007 Port imem_req_addr  output  32  meaning: word-aligned fetch address.
REQ-008 Port imem_rsp_valid  input  1  meaning: read data valid, in order, exactly one per accepted request, earliest one cycle after acceptance.
REQ-009 Port imem_rsp_data  input  32  meaning: fetched instruction word.
REQ-010 Port redirect_valid  input  1  meaning: taken branch/jump (PCsrc) from execute.
REQ-011 Port redirect_pc  input  32  meaning: branch target.
REQ-012 Port instr_valid  output  1  meaning: instr/instr_pc hold a valid instruction for the decoder.
REQ-013 Port instr_ready  input  1  meaning: decoder consumes head instruction this cycle.
REQ-014 Port instr  output  32  meaning: instruction to control unit.
REQ-015 Port instr_pc  output  32  meaning: address of instr.

Function
REQ-016 FSM states IDLE, REQ, WAIT, DRAIN SHALL be implemented; IDLE->REQ unconditionally one cycle after reset release.
REQ-017 imem_req_valid SHALL be 1 only in REQ and only when buffer count + outstanding requests < BUF_DEPTH; imem_req_addr SHALL equal fetch_pc.
REQ-018 A request is accepted when imem_req_valid && imem_req_ready; REQ->WAIT, fetch_pc SHALL advance by 4 (mod 2^32, wrap 32'hFFFF_FFFC->0).
REQ-019 At most one request SHALL be outstanding; WAIT->REQ on imem_rsp_valid, pushing {data, request pc} into the buffer.
REQ-020 Buffer SHALL be FIFO; instr_valid = (count != 0); instr/instr_pc = head entry; pop on instr_valid && instr_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 Push into a full buffer SHALL be impossible by REQ-017 credit rule; verification SHALL assert it.
REQ-022 redirect_valid SHALL have priority over all other events: buffer flushed (count=0, instr_valid 0 next cycle), fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-023 Redirect in REQ without acceptance: stay REQ. Redirect in REQ with same-cycle acceptance: go DRAIN (accepted request is stale).
REQ-024 Redirect in WAIT without imem_rsp_valid: go DRAIN. Redirect in WAIT with imem_rsp_valid: response discarded, go REQ.
REQ-025 In DRAIN, imem_rsp_valid SHALL be discarded (no push), go REQ; redirect in DRAIN updates fetch_pc, stays DRAIN unless rsp arrives same cycle (then REQ).
REQ-026 Pop in the flush cycle SHALL be honoured by the decoder side only; buffer result is empty regardless.
REQ-027 Fetch-to-instr_valid latency SHALL be: request accepted cycle N, rsp cycle N+k, instr_valid at N+k+1.

Reset
REQ-028 While rst_n low: state IDLE, fetch_pc RESET_PC, buffer count 0, imem_req_valid 0, instr_valid 0, instr 32'h0000_0013 (NOP), instr_pc 0.
REQ-029 Reset asserted mid-request SHALL abandon the transaction; memory is reset on the same rst_n, no drain required.

Structure
REQ-030 Shared package riscv_pkg SHALL hold fetch_state_t enum, INSTR_NOP constant, and XLEN=32.
REQ-031 Buffer SHALL be a sub-module fetch_fifo (parameter BUF_DEPTH, width 64, push/pop/flush, count).

Verification
REQ-032 Reset release, ready=1, 1-cycle memory, decoder ready -> addrs 0x0,0x4,0x8 requested, instr_pc sequence 0x0,0x4,0x8.
REQ-033 instr_ready=0 for 10 cycles -> exactly 2 instrs buffered, imem_req_valid 0 thereafter, no overflow.
REQ-034 Redirect to 0x100 while in WAIT, rsp arrives next cycle -> rsp dropped, next request addr 0x100, instr_valid 0 until it returns.
REQ-035 Redirect to 0x203 same cycle as rsp_valid in WAIT -> rsp dropped, next request addr 0x200.
REQ-036 fetch_pc 0xFFFF_FFFC accepted -> next request addr 0x0000_0000.
REQ-037 rst_n low mid-WAIT with 1 buffered instr -> instr_valid 0, imem_req_valid 0 immediately; after release first request addr RESET_PC.
